// File: rtl/ss_modulator.sv
// Spread-spectrum BPSK modulator: carrier NCO with sine lookup, chip NCO driving a
// Galois PRN generator, and a 32-bit data shifter reloaded once per 32 PRN epochs.
module ss_modulator (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  input  logic        SampleTick,
  output logic [15:0] DAC,
  output logic        PushDAC,
  output logic        EpochSeen
);

  localparam logic [31:0] A_CONTROL  = 32'hFE00_0800;
  localparam logic [31:0] A_SAMPLES  = 32'hFE00_0804;
  localparam logic [31:0] A_CAR_ADD  = 32'hFE00_0830;
  localparam logic [31:0] A_CAR_PH   = 32'hFE00_0834;
  localparam logic [31:0] A_CAR_ADJ  = 32'hFE00_0838;
  localparam logic [31:0] A_CHIP_FRQ = 32'hFE00_0A30;
  localparam logic [31:0] A_CHIP_PH  = 32'hFE00_0A34;
  localparam logic [31:0] A_CHIP_ADJ = 32'hFE00_0A38;
  localparam logic [31:0] A_PRN      = 32'hFE00_0A3C;
  localparam logic [31:0] A_TXDATA   = 32'hFE00_0C30;
  localparam logic [31:0] A_TXSTAT   = 32'hFE00_0C34;
  localparam logic [31:0] A_BITCNT   = 32'hFE00_0C38;

  logic        run;
  logic [31:0] sample_count, carrier_add, carrier_phase, carrier_adj;
  logic [31:0] chip_freq, chip_phase, chip_adj, tx_data, tx_shift;
  logic [3:0]  prn_hob;
  logic [13:0] prn_poly, prn_value;
  logic [4:0]  bit_count;
  logic        buf_full, underflow, epoch_flag;
  logic [15:0] sv_r;
  logic        s_r, vld_r;

  // Quarter-wave parabola: idx 0..8191 spans 0..pi/2, peak 32767.
  function automatic logic [15:0] sine_lut(input logic [12:0] idx);
    logic [27:0] p;
    p = {15'd0, idx} * (28'd16384 - {15'd0, idx});
    return p[26:11];
  endfunction

  logic        advance, chip_edge, epoch, wrap, status_rd, chip_bit, sgn;
  logic [1:0]  q;
  logic [12:0] v;
  logic [15:0] value_ext, t_full;
  logic [13:0] t, prn_next;
  logic [31:0] carrier_sum, chip_sum;

  always_comb begin
    advance     = run & SampleTick;
    q           = carrier_phase[31:30];
    v           = q[0] ? ~carrier_phase[29:17] : carrier_phase[29:17];
    value_ext   = {2'b00, prn_value};
    chip_bit    = value_ext[prn_hob];
    t_full      = value_ext & ~(16'd1 << prn_hob);
    t           = {t_full[12:0], 1'b0};
    prn_next    = chip_bit ? (t ^ prn_poly) : t;
    carrier_sum = carrier_phase + carrier_adj + carrier_add;
    chip_sum    = chip_phase + chip_adj + chip_freq;
    chip_edge   = advance & ~chip_phase[31] & chip_sum[31];
    epoch       = chip_edge & (prn_next == 14'h0001);
    wrap        = epoch & (bit_count == 5'd31);
    status_rd   = read & (addr == A_TXSTAT);
    sgn         = q[1] ^ chip_bit ^ tx_shift[31];
  end

  always_comb begin
    Rdata = 32'd0;
    if (rst && read) begin
      case (addr)
        A_CONTROL:  Rdata = {31'd0, run};
        A_SAMPLES:  Rdata = sample_count;
        A_CAR_ADD:  Rdata = carrier_add;
        A_CAR_PH:   Rdata = carrier_phase;
        A_CAR_ADJ:  Rdata = carrier_adj;
        A_CHIP_FRQ: Rdata = chip_freq;
        A_CHIP_PH:  Rdata = chip_phase;
        A_CHIP_ADJ: Rdata = chip_adj;
        A_PRN:      Rdata = {prn_hob, prn_poly, prn_value};
        A_TXDATA:   Rdata = tx_data;
        A_TXSTAT:   Rdata = {29'd0, epoch_flag, underflow, buf_full};
        A_BITCNT:   Rdata = {27'd0, bit_count};
        default:    Rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run <= 1'b0;           sample_count <= '0;  carrier_add <= '0;
      carrier_phase <= '0;   carrier_adj <= '0;   chip_freq <= '0;
      chip_phase <= '0;      chip_adj <= '0;      prn_hob <= '0;
      prn_poly <= '0;        prn_value <= '0;     tx_data <= '0;
      tx_shift <= '0;        bit_count <= '0;     buf_full <= 1'b0;
      underflow <= 1'b0;     epoch_flag <= 1'b0;  sv_r <= '0;
      s_r <= 1'b0;           vld_r <= 1'b0;       DAC <= '0;
      PushDAC <= 1'b0;       EpochSeen <= 1'b0;
    end else begin
      if (advance) begin
        carrier_phase <= carrier_sum;
        chip_phase    <= chip_sum;
        carrier_adj   <= '0;
        chip_adj      <= '0;
        sample_count  <= sample_count + 32'd1;
        sv_r          <= sine_lut(v);
        s_r           <= sgn;
        if (chip_edge) prn_value <= prn_next;
      end
      if (epoch) begin
        bit_count <= bit_count + 5'd1;
        tx_shift  <= tx_shift << 1;
        if (wrap) begin
          tx_shift <= buf_full ? tx_data : 32'd0;
          if (buf_full) buf_full  <= 1'b0;
          else          underflow <= 1'b1;
        end
      end
      // Status read-clear loses to a same-cycle set event.
      if (status_rd) begin
        if (!(wrap && !buf_full)) underflow <= 1'b0;
        if (!epoch)               epoch_flag <= 1'b0;
      end
      if (epoch) epoch_flag <= 1'b1;

      // Register writes land last so they override same-cycle advance updates.
      if (write) begin
        case (addr)
          A_CONTROL:  run           <= Wdata[0];
          A_SAMPLES:  sample_count  <= Wdata;
          A_CAR_ADD:  carrier_add   <= Wdata;
          A_CAR_PH:   carrier_phase <= Wdata;
          A_CAR_ADJ:  carrier_adj   <= Wdata;
          A_CHIP_FRQ: chip_freq     <= Wdata;
          A_CHIP_PH:  chip_phase    <= Wdata;
          A_CHIP_ADJ: chip_adj      <= Wdata;
          A_PRN:      {prn_hob, prn_poly, prn_value} <= Wdata;
          A_TXDATA: begin
            tx_data  <= Wdata;
            buf_full <= 1'b1;
          end
          default: ;
        endcase
      end

      vld_r     <= advance;
      PushDAC   <= vld_r;
      EpochSeen <= epoch;
      if (vld_r) DAC <= s_r ? -sv_r : sv_r;
    end
  end

endmodule

// File: tb/tb_ss_modulator.sv
// Directed self-checking bench for ss_modulator: register map, NCO/PRN stepping,
// DAC latency and sign, data reload/underflow, and synchronous reset.
module tb_ss_modulator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0, Wdata = '0;
  logic        write = 1'b0, read = 1'b0, SampleTick = 1'b0;
  logic [31:0] Rdata;
  logic [15:0] DAC;
  logic        PushDAC, EpochSeen;

  int tests = 0;
  int failed = 0;

  localparam logic [31:0] A_CONTROL  = 32'hFE00_0800;
  localparam logic [31:0] A_SAMPLES  = 32'hFE00_0804;
  localparam logic [31:0] A_CAR_ADD  = 32'hFE00_0830;
  localparam logic [31:0] A_CAR_PH   = 32'hFE00_0834;
  localparam logic [31:0] A_CAR_ADJ  = 32'hFE00_0838;
  localparam logic [31:0] A_CHIP_FRQ = 32'hFE00_0A30;
  localparam logic [31:0] A_CHIP_PH  = 32'hFE00_0A34;
  localparam logic [31:0] A_CHIP_ADJ = 32'hFE00_0A38;
  localparam logic [31:0] A_PRN      = 32'hFE00_0A3C;
  localparam logic [31:0] A_TXDATA   = 32'hFE00_0C30;
  localparam logic [31:0] A_TXSTAT   = 32'hFE00_0C34;
  localparam logic [31:0] A_BITCNT   = 32'hFE00_0C38;

  ss_modulator dut (
    .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write), .read(read),
    .Rdata(Rdata), .SampleTick(SampleTick), .DAC(DAC), .PushDAC(PushDAC),
    .EpochSeen(EpochSeen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; Wdata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; read = 1'b1;
    #1 d = Rdata;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  // Hold SampleTick for n consecutive cycles, then let the DAC pipeline drain.
  task automatic tick_n(input int n);
    @(negedge clk);
    SampleTick = 1'b1;
    repeat (n) @(negedge clk);
    SampleTick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  int pushes;

  initial begin
    // Reset state
    do_reset();
    rd_check("reset_control", A_CONTROL, 32'h0);
    rd_check("reset_txstat", A_TXSTAT, 32'h0);
    check("reset_dac", {16'd0, DAC}, 32'h0);
    check("reset_push", {31'd0, PushDAC}, 32'h0);

    // Register read/write, unmapped and read-only addresses
    wr(A_CAR_ADD, 32'h1234_5678);
    rd_check("rw_car_add", A_CAR_ADD, 32'h1234_5678);
    rd_check("unmapped", 32'hFE00_0808, 32'h0);
    wr(A_BITCNT, 32'h0000_0011);
    rd_check("ro_bitcnt", A_BITCNT, 32'h0);
    @(negedge clk);
    addr = A_CAR_ADD;
    #1 check("rdata_no_read", Rdata, 32'h0);

    // Ticks ignored while Run=0
    tick_n(3);
    rd_check("norun_samples", A_SAMPLES, 32'h0);

    // Latency: single advance from phase 0 -> one PushDAC two cycles later
    do_reset();
    wr(A_CONTROL, 32'h1);
    @(negedge clk);
    SampleTick = 1'b1;
    @(negedge clk);
    SampleTick = 1'b0;
    check("lat_push_c1", {31'd0, PushDAC}, 32'h0);
    @(negedge clk);
    check("lat_push_c2", {31'd0, PushDAC}, 32'h1);
    check("lat_dac", {16'd0, DAC}, 32'h0);
    pushes = 0;
    repeat (8) begin
      @(negedge clk);
      if (PushDAC) pushes++;
    end
    check("lat_no_extra_push", pushes, 0);

    // Carrier advance sum and Adj self-clear
    wr(A_CAR_ADD, 32'h0000_1000);
    wr(A_CAR_ADJ, 32'h0000_0010);
    tick_n(1);
    rd_check("car_phase_sum", A_CAR_PH, 32'h0000_1010);
    rd_check("car_adj_clear", A_CAR_ADJ, 32'h0);
    rd_check("sample_count", A_SAMPLES, 32'h2);

    // Write/advance collision on Chip_Adj
    wr(A_CHIP_FRQ, 32'h0000_0100);
    @(negedge clk);
    addr = A_CHIP_ADJ; Wdata = 32'h5; write = 1'b1; SampleTick = 1'b1;
    @(negedge clk);
    write = 1'b0; SampleTick = 1'b0;
    rd_check("coll_chip_adj", A_CHIP_ADJ, 32'h5);
    rd_check("coll_chip_phase", A_CHIP_PH, 32'h0000_0100);
    tick_n(1);
    rd_check("coll_next_phase", A_CHIP_PH, 32'h0000_0205);
    rd_check("coll_adj_clear", A_CHIP_ADJ, 32'h0);

    // PRN stepping: hob 3, poly 9, start 1 -> 2,4,8,9
    do_reset();
    wr(A_PRN, 32'h3002_4001);
    wr(A_CHIP_FRQ, 32'h8000_0000);
    wr(A_CONTROL, 32'h1);
    rd_check("prn_v1", A_PRN, 32'h3002_4001);
    tick_n(1);
    rd_check("prn_v2", A_PRN, 32'h3002_4002);
    tick_n(2);
    rd_check("prn_v4", A_PRN, 32'h3002_4004);
    tick_n(2);
    rd_check("prn_v8", A_PRN, 32'h3002_4008);
    tick_n(2);
    rd_check("prn_v9", A_PRN, 32'h3002_4009);

    // Data sign and reload: epoch on every chip edge (hob 0, poly 1, value 1)
    do_reset();
    wr(A_TXDATA, 32'h8000_0000);
    wr(A_PRN, 32'h0000_4001);
    wr(A_CHIP_FRQ, 32'h8000_0000);
    wr(A_CAR_PH, 32'h1000_0000);
    wr(A_CONTROL, 32'h1);
    @(negedge clk);
    SampleTick = 1'b1;
    @(negedge clk);
    SampleTick = 1'b0;
    check("epoch_pulse", {31'd0, EpochSeen}, 32'h1);
    @(negedge clk);
    check("epoch_pulse_end", {31'd0, EpochSeen}, 32'h0);
    tick_n(61);
    rd_check("bitcnt_31", A_BITCNT, 32'd31);
    check("dac_d0", {16'd0, DAC}, 32'h0000_C800);
    tick_n(2);
    rd_check("bitcnt_wrap", A_BITCNT, 32'd0);
    check("dac_d1", {16'd0, DAC}, 32'h0000_3800);
    rd_check("txstat_reload", A_TXSTAT, 32'h4);

    // Underflow after a further 32 epochs without a TxData write
    tick_n(64);
    check("dac_underflow", {16'd0, DAC}, 32'h0000_C800);
    rd_check("txstat_underflow", A_TXSTAT, 32'h6);
    rd_check("txstat_cleared", A_TXSTAT, 32'h0);

    // Reset mid-run
    wr(A_CAR_ADD, 32'h0100_0000);
    @(negedge clk);
    SampleTick = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0; addr = A_CONTROL; read = 1'b1;
    #1 check("rdata_in_reset", Rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1; read = 1'b0; SampleTick = 1'b0;
    check("rst_push", {31'd0, PushDAC}, 32'h0);
    check("rst_epoch", {31'd0, EpochSeen}, 32'h0);
    check("rst_dac", {16'd0, DAC}, 32'h0);
    pushes = 0;
    repeat (4) begin
      @(negedge clk);
      if (PushDAC) pushes++;
    end
    check("rst_no_push", pushes, 0);
    rd_check("rst_control", A_CONTROL, 32'h0);
    rd_check("rst_samples", A_SAMPLES, 32'h0);
    rd_check("rst_car_add", A_CAR_ADD, 32'h0);
    rd_check("rst_car_ph", A_CAR_PH, 32'h0);
    rd_check("rst_chip_ph", A_CHIP_PH, 32'h0);
    rd_check("rst_prn", A_PRN, 32'h0);
    rd_check("rst_txdata", A_TXDATA, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
